seven_segment_capture: RTL and testbench

// - Receive end of the multiplexed seven-segment display interface: samples scanned segment/anode lines
//   and reconstructs hex value per digit position, plus per-digit invalid-pattern flags.
// - Sits between display driver outputs and self-check logic / debug readback; one frame = every digit seen once.

---
 rtl/seven_segment_capture_pkg.sv | 31 +++
 rtl/seven_segment_capture_seg7_decode.sv | 26 ++
 rtl/seven_segment_capture.sv | 182 ++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_capture_pkg.sv
// Shared definitions for the seven-segment receive path: segment bit positions,
// the hex-to-segment pattern table and the capture FSM state encoding.
package seven_segment_capture_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int MAX_DIGITS = 8;

    // Index = hex value, entry = lit segments {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_TO_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } cap_state_e;

    function automatic logic is_one_hot(input logic [MAX_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - MAX_DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/seven_segment_capture_seg7_decode.sv
// Combinational seven-segment pattern decoder: maps a lit-segment pattern back to
// its hex nibble and flags patterns that are not in the hex table.
module seg7_decode
    import seven_segment_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    logic [6:0] pattern;

    always_comb begin
        pattern = {seg[SEG_G], seg[SEG_F], seg[SEG_E], seg[SEG_D],
                   seg[SEG_C], seg[SEG_B], seg[SEG_A]};
        valid   = 1'b0;
        nibble  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == HEX_TO_SEG[i]) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed seven-segment display: debounces the scanned
// anode/segment lines, decodes each digit slot and publishes whole frames.
module seven_segment_capture
    import seven_segment_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_DIGITS-1:0] an_s_q, an_s_d, an_p_q, an_p_d;
    logic [6:0]            seg_s_q, seg_s_d, seg_p_q, seg_p_d;
    cap_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic                  frame_valid_q, frame_valid_d;

    logic                  sample_onehot;
    logic                  sample_same;
    logic                  capture;
    logic                  frame_done;
    logic [IDX_W-1:0]      cap_idx;
    logic                  dec_valid;
    logic [3:0]            dec_nibble;

    seg7_decode u_decode (
        .seg    (seg_s_q),
        .valid  (dec_valid),
        .nibble (dec_nibble)
    );

    // Two-deep sample pipeline: current sample and the one before it
    always_comb begin
        an_s_d  = an_in;
        seg_s_d = seg_in;
        an_p_d  = an_s_q;
        seg_p_d = seg_s_q;
    end

    always_comb begin
        sample_onehot = is_one_hot(MAX_DIGITS'(an_s_q));
        sample_same   = (an_s_q == an_p_q) && (seg_s_q == seg_p_q);
        cap_idx       = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (an_s_q[k]) begin
                cap_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (sample_onehot) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_COUNT: begin
                if (sample_same) begin
                    // >= so that a single-cycle dwell requirement captures on entry
                    if (cnt_q >= CNT_LAST) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (sample_onehot) begin
                    cnt_d = CNT_ONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (!sample_same) begin
                    if (sample_onehot) begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // A frame completes the cycle after the last missing slot is captured
    always_comb begin
        frame_done    = &seen_q;
        frame_valid_d = frame_done;
        seen_d        = frame_done ? '0 : seen_q;
        if (capture) begin
            seen_d[cap_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s_q        <= '0;
            seg_s_q       <= '0;
            an_p_q        <= '0;
            seg_p_q       <= '0;
            state_q       <= ST_WAIT;
            cnt_q         <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            an_s_q        <= an_s_d;
            seg_s_q       <= seg_s_d;
            an_p_q        <= an_p_d;
            seg_p_q       <= seg_p_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [3:0] shadow_nib_q, shadow_nib_d;
            logic       shadow_err_q, shadow_err_d;
            logic [3:0] digit_q, digit_d;
            logic       derr_q, derr_d;
            logic       slot_we;

            // Shadow holds the partial frame; outputs only move on completion
            always_comb begin
                slot_we      = capture && (cap_idx == IDX_W'(gi));
                shadow_nib_d = slot_we ? dec_nibble : shadow_nib_q;
                shadow_err_d = slot_we ? ~dec_valid : shadow_err_q;
                digit_d      = frame_done ? shadow_nib_q : digit_q;
                derr_d       = frame_done ? shadow_err_q : derr_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_nib_q <= '0;
                    shadow_err_q <= 1'b0;
                    digit_q      <= '0;
                    derr_q       <= 1'b0;
                end else begin
                    shadow_nib_q <= shadow_nib_d;
                    shadow_err_q <= shadow_err_d;
                    digit_q      <= digit_d;
                    derr_q       <= derr_d;
                end
            end

            assign digits_out[4*gi +: 4] = digit_q;
            assign digit_err[gi]         = derr_q;
        end
    endgenerate

    assign frame_valid = frame_valid_q;
    assign busy        = |seen_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench for seven_segment_capture: directed scan scenarios plus a
// randomized scan stream compared against a dwell-level reference model.
module tb_seven_segment_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg_in = '0;
    logic [ND-1:0]     an_in = '0;
    logic [4*ND-1:0]   digits_out;
    logic [ND-1:0]     digit_err;
    logic              frame_valid;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] got_dig[$];
    logic [3:0]  got_err[$];

    // Reference model state: a run is a stretch of identical pin values
    logic [ND-1:0] m_an;
    logic [6:0]    m_seg;
    int            m_run;
    bit            m_capd;
    logic [3:0]    m_nib [ND];
    logic          m_err [ND];
    logic [ND-1:0] m_seen;
    logic [15:0]   exp_dig[$];
    logic [3:0]    exp_err[$];

    seven_segment_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            got_dig.push_back(digits_out);
            got_err.push_back(digit_err);
        end
    end

    task automatic model_reset();
        m_an   = '0;
        m_seg  = '0;
        m_run  = 0;
        m_capd = 0;
        m_seen = '0;
        for (int i = 0; i < ND; i++) begin
            m_nib[i] = '0;
            m_err[i] = 1'b0;
        end
        exp_dig.delete();
        exp_err.delete();
    endtask

    task automatic model_dwell(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
        int          slot;
        logic [3:0]  nib;
        logic        err;
        logic [15:0] fd;
        logic [3:0]  fe;
        if (an == m_an && seg == m_seg) begin
            m_run += n;
        end else begin
            m_an   = an;
            m_seg  = seg;
            m_run  = n;
            m_capd = 0;
        end
        slot = -1;
        if ($countones(an) == 1) begin
            for (int i = 0; i < ND; i++) if (an[i]) slot = i;
        end
        if (slot >= 0 && !m_capd && m_run >= SC) begin
            m_capd = 1;
            nib = 4'h0;
            err = 1'b1;
            for (int h = 0; h < 16; h++) begin
                if (SEG_TAB[h] == seg) begin
                    nib = 4'(h);
                    err = 1'b0;
                end
            end
            m_nib[slot] = nib;
            m_err[slot] = err;
            m_seen[slot] = 1'b1;
            if (m_seen == '1) begin
                for (int i = 0; i < ND; i++) begin
                    fd[4*i +: 4] = m_nib[i];
                    fe[i]        = m_err[i];
                end
                exp_dig.push_back(fd);
                exp_err.push_back(fe);
                m_seen = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        an_in  = '0;
        seg_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_dig.delete();
        got_err.delete();
        model_reset();
    endtask

    task automatic dwell(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
        model_dwell(an, seg, n);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        dwell(4'b0001, s0, 8);
        dwell(4'b0010, s1, 8);
        dwell(4'b0100, s2, 8);
        dwell(4'b1000, s3, 8);
        dwell(4'b0000, 7'h00, 6);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        do_reset();
        n_total++;
        if (digits_out !== 16'h0 || digit_err !== 4'h0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_state: got dig=%h err=%b fv=%b busy=%b, want 0/0/0/0",
                     digits_out, digit_err, frame_valid, busy);
        end else n_pass++;

        scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
        d = digits_out;
        n_total++;
        if (d !== 16'h4321) $display("FAIL reset_preframe: got %h want 4321", d);
        else n_pass++;

        dwell(4'b0001, 7'h7F, 8);
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_partial_busy: got %b want 1", busy);
        else n_pass++;

        #2;
        rst_n = 1'b0;
        got_dig.delete();
        got_err.delete();
        #1;
        n_total++;
        if (digits_out !== 16'h0 || digit_err !== 4'h0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            $display("FAIL reset_async_clear: got dig=%h err=%b busy=%b fv=%b, want all 0",
                     digits_out, digit_err, busy, frame_valid);
        end else n_pass++;

        an_in  = '0;
        seg_in = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        dwell(4'b0000, 7'h00, 10);
        n_total++;
        if (got_dig.size() != 0 || busy !== 1'b0) begin
            $display("FAIL reset_no_frame_after: got frames=%0d busy=%b, want 0/0", got_dig.size(), busy);
        end else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        int          lat;
        logic [15:0] d;
        logic [3:0]  e;
        do_reset();
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0100, 7'h4F, 8);
        an_in  = 4'b1000;
        seg_in = 7'h66;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_total++;
        if (lat != SC + 2) $display("FAIL full_latency: got %0d cycles want %0d", lat, SC + 2);
        else n_pass++;

        dwell(4'b0000, 7'h00, 6);
        d = (got_dig.size() > 0) ? got_dig[0] : 16'hxxxx;
        e = (got_err.size() > 0) ? got_err[0] : 4'hx;
        n_total++;
        if (got_dig.size() != 1) $display("FAIL full_frame_count: got %0d want 1", got_dig.size());
        else n_pass++;
        n_total++;
        if (d !== 16'h4321 || e !== 4'h0) $display("FAIL full_frame_value: got %h/%b want 4321/0000", d, e);
        else n_pass++;
        n_total++;
        if (digits_out !== 16'h4321 || busy !== 1'b0)
            $display("FAIL full_frame_hold: got %h busy=%b want 4321 busy=0", digits_out, busy);
        else n_pass++;
        $display("test_full_frame done latency=%0d", lat);
    endtask

    task automatic test_glitch();
        logic [15:0] d;
        do_reset();
        dwell(4'b0001, 7'h06, 3);
        dwell(4'b0001, 7'h5B, 6);
        dwell(4'b0010, 7'h4F, 8);
        dwell(4'b0100, 7'h66, 8);
        dwell(4'b1000, 7'h6D, 8);
        dwell(4'b0000, 7'h00, 6);
        d = (got_dig.size() > 0) ? got_dig[0] : 16'hxxxx;
        n_total++;
        if (got_dig.size() != 1 || d !== 16'h5432)
            $display("FAIL glitch_reject: got frames=%0d dig=%h want 1/5432", got_dig.size(), d);
        else n_pass++;
        $display("test_glitch done");
    endtask

    task automatic test_invalid();
        logic [15:0] d;
        logic [3:0]  e;
        do_reset();
        scan4(7'h06, 7'h5B, 7'h00, 7'h66);
        d = (got_dig.size() > 0) ? got_dig[0] : 16'hxxxx;
        e = (got_err.size() > 0) ? got_err[0] : 4'hx;
        n_total++;
        if (d !== 16'h4021 || e !== 4'b0100)
            $display("FAIL invalid_pattern: got %h/%b want 4021/0100", d, e);
        else n_pass++;
        $display("test_invalid done");
    endtask

    task automatic test_non_onehot();
        logic [15:0] d;
        do_reset();
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0011, 7'h7F, 5);
        n_total++;
        if (busy !== 1'b1) $display("FAIL nonhot_multi_busy: got %b want 1", busy);
        else n_pass++;
        dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0000, 7'h00, 5);
        n_total++;
        if (busy !== 1'b1) $display("FAIL nonhot_zero_busy: got %b want 1", busy);
        else n_pass++;
        dwell(4'b0100, 7'h4F, 8);
        dwell(4'b1000, 7'h66, 8);
        dwell(4'b0000, 7'h00, 6);
        d = (got_dig.size() > 0) ? got_dig[0] : 16'hxxxx;
        n_total++;
        if (got_dig.size() != 1 || d !== 16'h4321)
            $display("FAIL nonhot_frame: got frames=%0d dig=%h want 1/4321", got_dig.size(), d);
        else n_pass++;
        $display("test_non_onehot done");
    endtask

    task automatic test_rescan();
        logic [15:0] d;
        do_reset();
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0001, 7'h7F, 8);
        n_total++;
        if (got_dig.size() != 0) $display("FAIL rescan_early_frame: got %0d frames want 0", got_dig.size());
        else n_pass++;
        dwell(4'b0010, 7'h5B, 30);
        dwell(4'b0100, 7'h4F, 8);
        dwell(4'b1000, 7'h66, 8);
        dwell(4'b0000, 7'h00, 6);
        d = (got_dig.size() > 0) ? got_dig[0] : 16'hxxxx;
        n_total++;
        if (got_dig.size() != 1 || d !== 16'h4328)
            $display("FAIL rescan_frame: got frames=%0d dig=%h want 1/4328", got_dig.size(), d);
        else n_pass++;
        dwell(4'b0001, 7'h06, 40);
        n_total++;
        if (got_dig.size() != 1 || busy !== 1'b1 || digits_out !== 16'h4328)
            $display("FAIL rescan_long_dwell: got frames=%0d busy=%b dig=%h want 1/1/4328",
                     got_dig.size(), busy, digits_out);
        else n_pass++;
        $display("test_rescan done");
    endtask

    task automatic test_random();
        logic [ND-1:0] an;
        logic [6:0]    seg;
        int            a, b, r;
        do_reset();
        for (int t = 0; t < 120; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                an = ND'(1) << $urandom_range(0, ND - 1);
            end else if (r == 7) begin
                an = '0;
            end else begin
                a  = $urandom_range(0, ND - 1);
                b  = (a + $urandom_range(1, ND - 1)) % ND;
                an = (ND'(1) << a) | (ND'(1) << b);
            end
            if ($urandom_range(0, 4) != 0) seg = SEG_TAB[$urandom_range(0, 15)];
            else seg = 7'($urandom);
            dwell(an, seg, $urandom_range(1, 8));
        end
        dwell(4'b0000, 7'h00, 6);

        n_total++;
        if (got_dig.size() != exp_dig.size())
            $display("FAIL random_frame_count: got %0d want %0d", got_dig.size(), exp_dig.size());
        else n_pass++;
        for (int i = 0; i < exp_dig.size() && i < got_dig.size(); i++) begin
            n_total++;
            if (got_dig[i] !== exp_dig[i] || got_err[i] !== exp_err[i])
                $display("FAIL random_frame[%0d]: got %h/%b want %h/%b",
                         i, got_dig[i], got_err[i], exp_dig[i], exp_err[i]);
            else n_pass++;
        end
        n_total++;
        if (busy !== (|m_seen)) $display("FAIL random_busy: got %b want %b", busy, |m_seen);
        else n_pass++;
        $display("test_random done frames=%0d", exp_dig.size());
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_glitch();
        test_invalid();
        test_non_onehot();
        test_rescan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
